// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of NUM_INP valid/ready streams into one registered output stream
module stream_rr_arbiter #(
    parameter int NUM_INP    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = (NUM_INP > 1) ? $clog2(NUM_INP) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          testmode_i,
    input  logic [NUM_INP-1:0]            inp_valid_i,
    output logic [NUM_INP-1:0]            inp_ready_o,
    input  logic [NUM_INP*DATA_WIDTH-1:0] inp_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [IDX_WIDTH-1:0]          idx_o
);
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] win;
    logic                 found;
    logic                 reg_rdy;
    logic                 hs;
    logic                 unused_testmode;

    assign unused_testmode = testmode_i;
    assign reg_rdy         = ready_i | ~valid_o;
    assign inp_ready_o     = (reg_rdy & found & ~clr_i) ? (NUM_INP'(1) << win) : '0;
    assign hs              = |inp_ready_o;

    // first valid requester scanning upward from rr_ptr with wrap-around
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_INP; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NUM_INP) j = j - NUM_INP;
            if (!found && inp_valid_i[j]) begin
                win   = IDX_WIDTH'(j);
                found = 1'b1;
            end
        end
    end

    // output register and pointer; clear beats any handshake, stall holds everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            idx_o   <= '0;
            rr_ptr  <= '0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            idx_o   <= '0;
            rr_ptr  <= '0;
        end else if (hs) begin
            valid_o <= 1'b1;
            data_o  <= inp_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            idx_o   <= win;
            rr_ptr  <= (win == IDX_WIDTH'(NUM_INP-1)) ? '0 : win + 1'b1;
        end else if (reg_rdy) begin
            valid_o <= 1'b0;
        end
    end
endmodule
